// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues one aligned memory read per FETCH episode,
// waits (bounded) for the single-cycle ack, hands the word to the instruction
// register and reports misalignment or bus timeout as sticky faults.
//
// Handshakes: o_mem_rd is a level request held with o_mem_addr stable until
// a single-cycle i_mem_ack (data valid with it) or timeout; o_valid/o_instr
// are held stable until the consumer pulses i_fetch_over, which completes the
// transfer in that same cycle.
module instruction_fetch #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] state,
   input  logic [31:0] i_pc,
   input  logic        i_flush,
   output logic [31:0] o_mem_addr,
   output logic        o_mem_rd,
   input  logic [31:0] i_mem_data,
   input  logic        i_mem_ack,
   output logic [31:0] o_instr,
   output logic        o_valid,
   input  logic        i_fetch_over,
   output logic        o_misaligned,
   output logic        o_bus_error,
   output logic [31:0] o_fetch_count,
   output logic [2:0]  o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQ     = 3'd1,
      S_DELIVER = 3'd2,
      S_HOLD    = 3'd3,
      S_ERROR   = 3'd4
   } fsm_t;

   localparam logic [31:0] LP_NOP       = 32'h0000_0013;
   // Value of the wait counter on the last REQ cycle before timing out.
   localparam logic [7:0]  LP_WAIT_LAST = 8'(TIMEOUT - 1);

   fsm_t        r_fsm, w_fsm_nxt;
   logic [31:0] r_mem_addr, w_mem_addr_nxt;
   logic        r_mem_rd, w_mem_rd_nxt;
   logic [31:0] r_instr, w_instr_nxt;
   logic        r_valid, w_valid_nxt;
   logic        r_misaligned, w_misaligned_nxt;
   logic        r_bus_error, w_bus_error_nxt;
   logic [31:0] r_fetch_count, w_fetch_count_nxt;
   logic [7:0]  r_wait, w_wait_nxt;
   logic        w_cpu_fetch;

   assign w_cpu_fetch = (state == 32'h0);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_fsm <= S_IDLE;
      else        r_fsm <= w_fsm_nxt;
   end

   // Next-state and next register values; flush overrides every state.
   always_comb begin
      w_fsm_nxt         = r_fsm;
      w_mem_addr_nxt    = r_mem_addr;
      w_mem_rd_nxt      = r_mem_rd;
      w_instr_nxt       = r_instr;
      w_valid_nxt       = r_valid;
      w_misaligned_nxt  = r_misaligned;
      w_bus_error_nxt   = r_bus_error;
      w_fetch_count_nxt = r_fetch_count;
      w_wait_nxt        = r_wait;
      if (i_flush) begin
         w_fsm_nxt        = S_IDLE;
         w_mem_rd_nxt     = 1'b0;
         w_valid_nxt      = 1'b0;
         w_misaligned_nxt = 1'b0;
         w_bus_error_nxt  = 1'b0;
         w_wait_nxt       = 8'd0;
      end else begin
         case (r_fsm)
            S_IDLE: begin
               if (w_cpu_fetch) begin
                  if (i_pc[1:0] == 2'b00) begin
                     w_mem_addr_nxt = i_pc;
                     w_mem_rd_nxt   = 1'b1;
                     w_wait_nxt     = 8'd0;
                     w_fsm_nxt      = S_REQ;
                  end else begin
                     w_misaligned_nxt = 1'b1;
                     w_fsm_nxt        = S_ERROR;
                  end
               end
            end
            S_REQ: begin
               // An ack on the final allowed cycle still completes the fetch.
               if (i_mem_ack) begin
                  w_instr_nxt  = i_mem_data;
                  w_mem_rd_nxt = 1'b0;
                  w_valid_nxt  = 1'b1;
                  w_fsm_nxt    = S_DELIVER;
               end else if (r_wait == LP_WAIT_LAST) begin
                  w_mem_rd_nxt    = 1'b0;
                  w_bus_error_nxt = 1'b1;
                  w_fsm_nxt       = S_ERROR;
               end else begin
                  w_wait_nxt = r_wait + 8'd1;
               end
            end
            S_DELIVER: begin
               if (i_fetch_over) begin
                  w_valid_nxt       = 1'b0;
                  w_fetch_count_nxt = r_fetch_count + 32'd1;
                  w_fsm_nxt         = S_HOLD;
               end
            end
            S_HOLD: begin
               // Wait for the CPU to leave FETCH so each episode fetches once.
               if (!w_cpu_fetch) w_fsm_nxt = S_IDLE;
            end
            S_ERROR: begin
               // Faults stay latched until a flush.
            end
            default: w_fsm_nxt = S_IDLE;
         endcase
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mem_addr    <= 32'h0;
         r_mem_rd      <= 1'b0;
         r_instr       <= LP_NOP;
         r_valid       <= 1'b0;
         r_misaligned  <= 1'b0;
         r_bus_error   <= 1'b0;
         r_fetch_count <= 32'h0;
         r_wait        <= 8'd0;
      end else begin
         r_mem_addr    <= w_mem_addr_nxt;
         r_mem_rd      <= w_mem_rd_nxt;
         r_instr       <= w_instr_nxt;
         r_valid       <= w_valid_nxt;
         r_misaligned  <= w_misaligned_nxt;
         r_bus_error   <= w_bus_error_nxt;
         r_fetch_count <= w_fetch_count_nxt;
         r_wait        <= w_wait_nxt;
      end
   end

   assign o_mem_addr    = r_mem_addr;
   assign o_mem_rd      = r_mem_rd;
   assign o_instr       = r_instr;
   assign o_valid       = r_valid;
   assign o_misaligned  = r_misaligned;
   assign o_bus_error   = r_bus_error;
   assign o_fetch_count = r_fetch_count;
   assign o_dbg_state   = r_fsm;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch (TIMEOUT=4). Scenario tasks know, from the
// fetch rules, what every output must be after each clock edge and keep that
// in exp_* variables; a negedge process compares all outputs every cycle.
module tb_instruction_fetch;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] cpu_state;
   logic [31:0] i_pc;
   logic        i_flush;
   logic [31:0] o_mem_addr;
   logic        o_mem_rd;
   logic [31:0] i_mem_data;
   logic        i_mem_ack;
   logic [31:0] o_instr;
   logic        o_valid;
   logic        i_fetch_over;
   logic        o_misaligned;
   logic        o_bus_error;
   logic [31:0] o_fetch_count;
   logic [2:0]  o_dbg_state;

   // Expected outputs after the most recent edge.
   logic [31:0] exp_addr, exp_instr, exp_count;
   logic        exp_rd, exp_valid, exp_mis, exp_berr;
   logic        chk_en = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          rd_cycles;

   instruction_fetch #(.TIMEOUT(TO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .state         (cpu_state),
      .i_pc          (i_pc),
      .i_flush       (i_flush),
      .o_mem_addr    (o_mem_addr),
      .o_mem_rd      (o_mem_rd),
      .i_mem_data    (i_mem_data),
      .i_mem_ack     (i_mem_ack),
      .o_instr       (o_instr),
      .o_valid       (o_valid),
      .i_fetch_over  (i_fetch_over),
      .o_misaligned  (o_misaligned),
      .o_bus_error   (o_bus_error),
      .o_fetch_count (o_fetch_count),
      .o_dbg_state   (o_dbg_state)
   );

   // Clock.
   always #5 clk = ~clk;

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the expected state.
   always @(negedge clk) begin
      if (chk_en) begin
         check("mem_addr", o_mem_addr, exp_addr);
         check("mem_rd", 32'(o_mem_rd), 32'(exp_rd));
         check("instr", o_instr, exp_instr);
         check("valid", 32'(o_valid), 32'(exp_valid));
         check("misaligned", 32'(o_misaligned), 32'(exp_mis));
         check("bus_error", 32'(o_bus_error), 32'(exp_berr));
         check("fetch_count", o_fetch_count, exp_count);
         check("at_most_one", 32'($countones({o_mem_rd, o_valid, o_misaligned, o_bus_error}) <= 1), 32'd1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_reset();
      exp_addr  = 32'h0;
      exp_instr = 32'h0000_0013;
      exp_count = 32'h0;
      exp_rd    = 1'b0;
      exp_valid = 1'b0;
      exp_mis   = 1'b0;
      exp_berr  = 1'b0;
   endtask

   // One complete fetch episode from IDLE (cpu_state != 0 on entry):
   // ack on REQ cycle ack_at, consumer waits 'hold' cycles before accepting.
   task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data,
                           input int ack_at, input int hold);
      i_pc = pc;
      cpu_state = 32'h0;
      tick();
      exp_rd = 1'b1;
      exp_addr = pc;
      i_pc = pc ^ 32'h0000_1000;   // address must not follow i_pc during REQ
      for (int k = 1; k <= ack_at; k++) begin
         i_mem_ack = (k == ack_at);
         i_mem_data = (k == ack_at) ? data : 32'hBAD0_0000 + 32'(k);
         tick();
      end
      i_mem_ack = 1'b0;
      i_mem_data = 32'hFFFF_0000;
      exp_rd = 1'b0;
      exp_valid = 1'b1;
      exp_instr = data;
      for (int k = 0; k < hold; k++) tick();
      i_fetch_over = 1'b1;
      tick();
      i_fetch_over = 1'b0;
      exp_valid = 1'b0;
      exp_count = exp_count + 32'd1;
      cpu_state = 32'h1;
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      cpu_state = 32'h1;
      i_pc = 32'h0;
      i_flush = 1'b0;
      i_mem_data = 32'h0;
      i_mem_ack = 1'b0;
      i_fetch_over = 1'b0;
      exp_reset();
      tick();
      chk_en = 1'b1;
      tick();
      check("reset_nop", o_instr, 32'h0000_0013);
      rst_n = 1'b1;
      tick();

      // Basic fetch: ack on 3rd REQ cycle, then 10 cycles still in FETCH.
      i_pc = 32'h100;
      cpu_state = 32'h0;
      tick();
      exp_rd = 1'b1;
      exp_addr = 32'h100;
      check("basic_addr", o_mem_addr, 32'h100);
      i_pc = 32'h104;
      tick();
      tick();
      i_mem_ack = 1'b1;
      i_mem_data = 32'h00A0_0093;
      tick();
      i_mem_ack = 1'b0;
      exp_rd = 1'b0;
      exp_valid = 1'b1;
      exp_instr = 32'h00A0_0093;
      check("basic_valid", 32'(o_valid), 32'd1);
      check("basic_instr", o_instr, 32'h00A0_0093);
      tick();
      i_fetch_over = 1'b1;
      tick();
      i_fetch_over = 1'b0;
      exp_valid = 1'b0;
      exp_count = 32'd1;
      check("basic_count", o_fetch_count, 32'd1);
      rd_cycles = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         rd_cycles += int'(o_mem_rd);
      end
      check("hold_no_refetch", 32'(rd_cycles), 32'd0);
      cpu_state = 32'h1;
      tick();

      // Ack on the last allowed REQ cycle wins over the timeout.
      do_fetch(32'h40, 32'h0051_0113, TO, 0);
      check("late_ack_instr", o_instr, 32'h0051_0113);
      do_fetch(32'h44, 32'h1234_5678, 1, 2);

      // Timeout: no ack at all.
      i_pc = 32'h80;
      cpu_state = 32'h0;
      rd_cycles = 0;
      tick();
      exp_rd = 1'b1;
      exp_addr = 32'h80;
      for (int k = 0; k < TO; k++) begin
         rd_cycles += int'(o_mem_rd);
         tick();
      end
      exp_rd = 1'b0;
      exp_berr = 1'b1;
      check("timeout_rd_cycles", 32'(rd_cycles), 32'd4);
      check("timeout_berr", 32'(o_bus_error), 32'd1);
      tick();
      i_mem_ack = 1'b1;           // stray ack in ERROR
      i_mem_data = 32'hDEAD_BEEF;
      tick();
      i_mem_ack = 1'b0;
      tick();
      i_flush = 1'b1;
      cpu_state = 32'h1;
      tick();
      i_flush = 1'b0;
      exp_berr = 1'b0;
      tick();

      // Misaligned PC.
      i_pc = 32'h102;
      cpu_state = 32'h0;
      tick();
      exp_mis = 1'b1;
      check("misaligned_flag", 32'(o_misaligned), 32'd1);
      tick();
      tick();
      tick();
      i_flush = 1'b1;
      cpu_state = 32'h1;
      tick();
      i_flush = 1'b0;
      exp_mis = 1'b0;
      tick();

      // Flush and ack together in REQ, then a stray ack in IDLE.
      i_pc = 32'h300;
      cpu_state = 32'h0;
      tick();
      exp_rd = 1'b1;
      exp_addr = 32'h300;
      i_mem_ack = 1'b1;
      i_mem_data = 32'hCAFE_F00D;
      i_flush = 1'b1;
      cpu_state = 32'h1;
      tick();
      i_mem_ack = 1'b0;
      i_flush = 1'b0;
      exp_rd = 1'b0;
      tick();
      i_mem_ack = 1'b1;
      i_mem_data = 32'h0BAD_0BAD;
      tick();
      i_mem_ack = 1'b0;
      tick();
      check("flush_instr_kept", o_instr, 32'h1234_5678);

      // Flush beats i_fetch_over in DELIVER: no count increment.
      i_pc = 32'h200;
      cpu_state = 32'h0;
      tick();
      exp_rd = 1'b1;
      exp_addr = 32'h200;
      i_mem_ack = 1'b1;
      i_mem_data = 32'h0000_0073;
      tick();
      i_mem_ack = 1'b0;
      exp_rd = 1'b0;
      exp_valid = 1'b1;
      exp_instr = 32'h0000_0073;
      i_flush = 1'b1;
      i_fetch_over = 1'b1;
      cpu_state = 32'h1;
      tick();
      i_flush = 1'b0;
      i_fetch_over = 1'b0;
      exp_valid = 1'b0;
      check("flush_count_kept", o_fetch_count, 32'd3);
      tick();

      // Counter wrap.
      force dut.r_fetch_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_fetch_count;
      exp_count = 32'hFFFF_FFFF;
      tick();
      do_fetch(32'h400, 32'h0020_8093, 2, 1);
      check("count_wrap", o_fetch_count, 32'd0);
      do_fetch(32'h404, 32'h0030_8093, 1, 0);

      // Reset in the middle of DELIVER.
      i_pc = 32'h500;
      cpu_state = 32'h0;
      tick();
      exp_rd = 1'b1;
      exp_addr = 32'h500;
      i_mem_ack = 1'b1;
      i_mem_data = 32'h0040_8093;
      tick();
      i_mem_ack = 1'b0;
      exp_rd = 1'b0;
      exp_valid = 1'b1;
      exp_instr = 32'h0040_8093;
      rst_n = 1'b0;
      cpu_state = 32'h1;
      tick();
      exp_reset();
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_instr", o_instr, 32'h0000_0013);
      check("rst_count", o_fetch_count, 32'd0);
      rst_n = 1'b1;
      tick();
      do_fetch(32'h600, 32'h0050_8093, 3, 0);
      tick();

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
